// File: rtl/img_pkg.sv
// Shared definitions for the image data-memory path.
//   arb_state_t          : write-port arbiter states
//   REQ_CAM / REQ_HOST   : requester indices (bit positions in err_drop / rearm)
//   DMEM_ADDR_W / _DATA_W: default dmem geometry (128 lines x 16 px x 16 b)
package img_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CAM  = 2'd1,
    GNT_HOST = 2'd2
  } arb_state_t;

  localparam int unsigned REQ_CAM     = 0;
  localparam int unsigned REQ_HOST    = 1;

  localparam int unsigned DMEM_ADDR_W = 7;
  localparam int unsigned DMEM_DATA_W = 256;

endpackage

// File: rtl/dmem_wr_arbiter.sv
// Arbitrates the single dmem write port between the camera capture path
// (CAM) and the SPART host image loader (HOST). Grants are locked for a
// burst and released by dropping req, or revoked after MAX_BURST writes.
// Ports:
//   pxlclk, rst                 : clock, synchronous active-high reset
//   cam_req/host_req            : request / hold the port
//   cam_wren/addr/data          : CAM write strobe, address, data
//   host_wren/addr/data         : HOST write strobe, address, data
//   cam_gnt/host_gnt            : registered grants
//   clr_err                     : pulse clearing err_drop (a same-cycle drop wins)
//   dmem_wren/addr/data         : registered dmem write port
//   err_drop                    : sticky dropped-write flags {HOST, CAM}
//   busy                        : either grant is high
module dmem_wr_arbiter
  import img_pkg::*;
#(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W
) (
  input  logic              pxlclk,
  input  logic              rst,
  input  logic              cam_req,
  input  logic              host_req,
  input  logic              cam_wren,
  input  logic              host_wren,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] cam_data,
  input  logic [DATA_W-1:0] host_data,
  output logic              cam_gnt,
  output logic              host_gnt,
  input  logic              clr_err,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data,
  output logic [1:0]        err_drop,
  output logic              busy
);

  localparam logic [6:0] LP_MAXB = 7'(MAX_BURST);
  localparam logic       L_CAM   = 1'(REQ_CAM);
  localparam logic       L_HOST  = 1'(REQ_HOST);

  arb_state_t        r_state, w_state_nxt;
  logic              r_last, w_last_nxt;
  logic [6:0]        r_wcnt, w_wcnt_nxt, w_wcnt_inc;
  logic [1:0]        r_rearm, w_rearm_nxt;
  logic [1:0]        r_err;
  logic              r_dmem_wren;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_data;

  logic w_cam_gnt, w_host_gnt;
  logic w_cam_elig, w_host_elig;
  logic w_cam_acc, w_host_acc;
  logic w_cam_drop, w_host_drop;

  assign w_cam_elig  = cam_req  & ~r_rearm[REQ_CAM];
  assign w_host_elig = host_req & ~r_rearm[REQ_HOST];
  assign w_cam_acc   = cam_wren  &  w_cam_gnt;
  assign w_host_acc  = host_wren &  w_host_gnt;
  assign w_cam_drop  = cam_wren  & ~w_cam_gnt;
  assign w_host_drop = host_wren & ~w_host_gnt;
  assign w_wcnt_inc  = r_wcnt + 7'd1;

  // State register
  always_ff @(posedge pxlclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= L_HOST;
      r_wcnt  <= '0;
      r_rearm <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rearm <= w_rearm_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_wcnt_nxt  = r_wcnt;
    w_rearm_nxt = r_rearm;
    // rearm is released by any cycle with req low; a revoke below re-sets it
    if (!cam_req)  w_rearm_nxt[REQ_CAM]  = 1'b0;
    if (!host_req) w_rearm_nxt[REQ_HOST] = 1'b0;
    case (r_state)
      IDLE: begin
        w_wcnt_nxt = '0;
        if (w_cam_elig && w_host_elig)
          w_state_nxt = (r_last == L_CAM) ? GNT_HOST : GNT_CAM;
        else if (w_cam_elig)
          w_state_nxt = GNT_CAM;
        else if (w_host_elig)
          w_state_nxt = GNT_HOST;
      end
      GNT_CAM: begin
        if (cam_wren) w_wcnt_nxt = w_wcnt_inc;
        if (cam_wren && (w_wcnt_inc == LP_MAXB)) begin
          w_state_nxt          = IDLE;
          w_last_nxt           = L_CAM;
          w_wcnt_nxt           = '0;
          w_rearm_nxt[REQ_CAM] = 1'b1;
        end else if (!cam_req) begin
          w_state_nxt = IDLE;
          w_last_nxt  = L_CAM;
          w_wcnt_nxt  = '0;
        end
      end
      GNT_HOST: begin
        if (host_wren) w_wcnt_nxt = w_wcnt_inc;
        if (host_wren && (w_wcnt_inc == LP_MAXB)) begin
          w_state_nxt           = IDLE;
          w_last_nxt            = L_HOST;
          w_wcnt_nxt            = '0;
          w_rearm_nxt[REQ_HOST] = 1'b1;
        end else if (!host_req) begin
          w_state_nxt = IDLE;
          w_last_nxt  = L_HOST;
          w_wcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // Output decode: grants come straight from the state register
  always_comb begin
    w_cam_gnt  = (r_state == GNT_CAM);
    w_host_gnt = (r_state == GNT_HOST);
  end

  // Write forwarding stage and sticky drop flags
  always_ff @(posedge pxlclk) begin
    if (rst) begin
      r_dmem_wren <= 1'b0;
      r_dmem_addr <= '0;
      r_dmem_data <= '0;
      r_err       <= '0;
    end else begin
      r_dmem_wren <= w_cam_acc | w_host_acc;
      if (w_cam_acc) begin
        r_dmem_addr <= cam_addr;
        r_dmem_data <= cam_data;
      end else if (w_host_acc) begin
        r_dmem_addr <= host_addr;
        r_dmem_data <= host_data;
      end
      r_err[REQ_CAM]  <= w_cam_drop  | (r_err[REQ_CAM]  & ~clr_err);
      r_err[REQ_HOST] <= w_host_drop | (r_err[REQ_HOST] & ~clr_err);
    end
  end

  assign cam_gnt   = w_cam_gnt;
  assign host_gnt  = w_host_gnt;
  assign busy      = w_cam_gnt | w_host_gnt;
  assign dmem_wren = r_dmem_wren;
  assign dmem_addr = r_dmem_addr;
  assign dmem_data = r_dmem_data;
  assign err_drop  = r_err;

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Directed bench for dmem_wr_arbiter: a default instance (MAX_BURST = 64)
// and a MAX_BURST = 4 instance share all inputs. Inputs are driven 1 time
// unit after each rising edge; registered outputs are sampled at that point.
module tb_dmem_wr_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 256;

  logic          pxlclk = 1'b0;
  logic          rst = 1'b0;
  logic          cam_req = 1'b0, host_req = 1'b0;
  logic          cam_wren = 1'b0, host_wren = 1'b0;
  logic [AW-1:0] cam_addr = '0, host_addr = '0;
  logic [DW-1:0] cam_data = '0, host_data = '0;
  logic          clr_err = 1'b0;

  logic          cam_gnt, host_gnt, dmem_wren, busy;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_data;
  logic [1:0]    err_drop;

  logic          cam_gnt4, host_gnt4, dmem_wren4, busy4;
  logic [AW-1:0] dmem_addr4;
  logic [DW-1:0] dmem_data4;
  logic [1:0]    err_drop4;

  int checks = 0;
  int errors = 0;

  always #5 pxlclk = ~pxlclk;

  dmem_wr_arbiter u_dut (
    .pxlclk(pxlclk), .rst(rst),
    .cam_req(cam_req), .host_req(host_req),
    .cam_wren(cam_wren), .host_wren(host_wren),
    .cam_addr(cam_addr), .host_addr(host_addr),
    .cam_data(cam_data), .host_data(host_data),
    .cam_gnt(cam_gnt), .host_gnt(host_gnt),
    .clr_err(clr_err),
    .dmem_wren(dmem_wren), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
    .err_drop(err_drop), .busy(busy)
  );

  dmem_wr_arbiter #(.MAX_BURST(4)) u_dut4 (
    .pxlclk(pxlclk), .rst(rst),
    .cam_req(cam_req), .host_req(host_req),
    .cam_wren(cam_wren), .host_wren(host_wren),
    .cam_addr(cam_addr), .host_addr(host_addr),
    .cam_data(cam_data), .host_data(host_data),
    .cam_gnt(cam_gnt4), .host_gnt(host_gnt4),
    .clr_err(clr_err),
    .dmem_wren(dmem_wren4), .dmem_addr(dmem_addr4), .dmem_data(dmem_data4),
    .err_drop(err_drop4), .busy(busy4)
  );

  task automatic step();
    @(posedge pxlclk);
    #1;
  endtask

  task automatic do_reset();
    cam_req = 0; host_req = 0; cam_wren = 0; host_wren = 0; clr_err = 0;
    cam_addr = '0; host_addr = '0; cam_data = '0; host_data = '0;
    rst = 1;
    step();
    rst = 0;
  endtask

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {16{v}};
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (cam_gnt !== 1'b0) begin errors++; $display("FAIL reset_cam_gnt: got %b exp 0", cam_gnt); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL reset_host_gnt: got %b exp 0", host_gnt); end
    checks++; if (dmem_wren !== 1'b0) begin errors++; $display("FAIL reset_dmem_wren: got %b exp 0", dmem_wren); end
    checks++; if (dmem_addr !== '0) begin errors++; $display("FAIL reset_dmem_addr: got %h exp 0", dmem_addr); end
    checks++; if (dmem_data !== '0) begin errors++; $display("FAIL reset_dmem_data: got %h exp 0", dmem_data); end
    checks++; if (err_drop !== 2'b00) begin errors++; $display("FAIL reset_err_drop: got %b exp 00", err_drop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
  endtask

  task automatic test_cam_only();
    logic [15:0] v;
    do_reset();
    cam_req = 1;
    step();
    checks++; if (cam_gnt !== 1'b1 || host_gnt !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL cam_only_grant: got cam=%b host=%b busy=%b exp 1 0 1", cam_gnt, host_gnt, busy); end
    for (int a = 1; a <= 49; a++) begin
      v = 16'(a);
      cam_wren = 1; cam_addr = AW'(a); cam_data = rep(v);
      step();
      checks++; if (dmem_wren !== 1'b1 || dmem_addr !== AW'(a) || dmem_data !== rep(v)) begin
        errors++; $display("FAIL cam_only_write%0d: got wren=%b addr=%0d data=%h exp 1 %0d %h",
                           a, dmem_wren, dmem_addr, dmem_data[31:0], a, v); end
    end
    cam_wren = 0; cam_addr = '0; cam_data = '0;
    step();
    checks++; if (dmem_wren !== 1'b0 || dmem_addr !== AW'(49) || dmem_data !== rep(16'd49)) begin
      errors++; $display("FAIL cam_only_hold: got wren=%b addr=%0d exp 0 49", dmem_wren, dmem_addr); end
    checks++; if (err_drop !== 2'b00 || cam_gnt !== 1'b1) begin
      errors++; $display("FAIL cam_only_err: got err=%b gnt=%b exp 00 1", err_drop, cam_gnt); end
    cam_req = 0;
    step();
    checks++; if (cam_gnt !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL cam_only_release: got gnt=%b busy=%b exp 0 0", cam_gnt, busy); end
  endtask

  task automatic test_tie();
    do_reset();
    cam_req = 1; host_req = 1;
    step();
    checks++; if (cam_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      errors++; $display("FAIL tie_first: got cam=%b host=%b exp 1 0", cam_gnt, host_gnt); end
    cam_req = 0;
    step();
    checks++; if (cam_gnt !== 1'b0 || host_gnt !== 1'b0) begin
      errors++; $display("FAIL tie_idle: got cam=%b host=%b exp 0 0", cam_gnt, host_gnt); end
    step();
    checks++; if (cam_gnt !== 1'b0 || host_gnt !== 1'b1) begin
      errors++; $display("FAIL tie_second: got cam=%b host=%b exp 0 1", cam_gnt, host_gnt); end
    host_req = 0;
    step();
  endtask

  task automatic test_round_robin();
    int e;
    logic [AW-1:0] a;
    do_reset();
    cam_req = 1; host_req = 1;
    step();
    for (int g = 0; g < 4; g++) begin
      e = g % 2;
      checks++; if (cam_gnt !== (e == 0) || host_gnt !== (e == 1)) begin
        errors++; $display("FAIL rr_grant%0d: got cam=%b host=%b exp requester %0d", g, cam_gnt, host_gnt, e); end
      for (int k = 0; k < 2; k++) begin
        a = AW'(8 * g + k + 1);
        if (e == 0) begin cam_wren = 1; cam_addr = a; cam_data = rep(16'(a)); end
        else        begin host_wren = 1; host_addr = a; host_data = rep(16'(a)); end
        step();
        checks++; if (dmem_wren !== 1'b1 || dmem_addr !== a || dmem_data !== rep(16'(a))) begin
          errors++; $display("FAIL rr_write%0d_%0d: got wren=%b addr=%0d exp 1 %0d", g, k, dmem_wren, dmem_addr, a); end
      end
      cam_wren = 0; host_wren = 0;
      if (e == 0) cam_req = 0; else host_req = 0;
      step();
      checks++; if (cam_gnt !== 1'b0 || host_gnt !== 1'b0) begin
        errors++; $display("FAIL rr_idle%0d: got cam=%b host=%b exp 0 0", g, cam_gnt, host_gnt); end
      if (e == 0) cam_req = 1; else host_req = 1;
      step();
    end
    cam_req = 0; host_req = 0;
    step();
  endtask

  task automatic test_drop();
    do_reset();
    cam_req = 1;
    step();
    host_wren = 1; host_addr = AW'(5); host_data = rep(16'h0005);
    step();
    checks++; if (dmem_wren !== 1'b0 || dmem_addr === AW'(5)) begin
      errors++; $display("FAIL drop_fwd: got wren=%b addr=%0d exp 0 !5", dmem_wren, dmem_addr); end
    checks++; if (err_drop !== 2'b10) begin errors++; $display("FAIL drop_flag: got %b exp 10", err_drop); end
    host_wren = 0; clr_err = 1;
    step();
    clr_err = 0;
    checks++; if (err_drop !== 2'b00) begin errors++; $display("FAIL drop_clear: got %b exp 00", err_drop); end
    host_wren = 1; clr_err = 1;
    step();
    host_wren = 0; clr_err = 0;
    checks++; if (err_drop !== 2'b10) begin errors++; $display("FAIL drop_beats_clear: got %b exp 10", err_drop); end
    // write in the same cycle req rises is dropped
    do_reset();
    host_req = 1; host_wren = 1; host_addr = AW'(9); host_data = rep(16'h0009);
    step();
    host_wren = 0;
    checks++; if (host_gnt !== 1'b1 || dmem_wren !== 1'b0 || err_drop !== 2'b10) begin
      errors++; $display("FAIL drop_req_edge: got gnt=%b wren=%b err=%b exp 1 0 10", host_gnt, dmem_wren, err_drop); end
    host_req = 0;
    step();
  endtask

  task automatic test_burst_limit();
    logic [AW-1:0] a;
    do_reset();
    cam_req = 1;
    step();
    checks++; if (cam_gnt4 !== 1'b1) begin errors++; $display("FAIL burst_grant: got %b exp 1", cam_gnt4); end
    for (int k = 0; k < 6; k++) begin
      a = AW'(20 + k);
      cam_wren = 1; cam_addr = a; cam_data = rep(16'(a));
      step();
      if (k < 4) begin
        checks++; if (dmem_wren4 !== 1'b1 || dmem_addr4 !== a) begin
          errors++; $display("FAIL burst_write%0d: got wren=%b addr=%0d exp 1 %0d", k, dmem_wren4, dmem_addr4, a); end
      end else begin
        checks++; if (dmem_wren4 !== 1'b0 || err_drop4 !== 2'b01) begin
          errors++; $display("FAIL burst_overrun%0d: got wren=%b err=%b exp 0 01", k, dmem_wren4, err_drop4); end
      end
      if (k == 3) begin
        checks++; if (cam_gnt4 !== 1'b0) begin errors++; $display("FAIL burst_revoke: got %b exp 0", cam_gnt4); end
      end
    end
    cam_wren = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (cam_gnt4 !== 1'b0) begin errors++; $display("FAIL burst_rearm%0d: got %b exp 0", k, cam_gnt4); end
    end
    cam_req = 0;
    step();
    cam_req = 1;
    step();
    checks++; if (cam_gnt4 !== 1'b1) begin errors++; $display("FAIL burst_regrant: got %b exp 1", cam_gnt4); end
    // a fresh burst gets the full MAX_BURST again
    for (int k = 0; k < 4; k++) begin
      cam_wren = 1; cam_addr = AW'(40 + k);
      step();
      checks++; if (cam_gnt4 !== (k < 3) || dmem_wren4 !== 1'b1) begin
        errors++; $display("FAIL burst2_%0d: got gnt=%b wren=%b exp %b 1", k, cam_gnt4, dmem_wren4, k < 3); end
    end
    cam_wren = 0; cam_req = 0;
    step();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    host_req = 1;
    step();
    for (int k = 0; k < 10; k++) begin
      host_wren = 1; host_addr = AW'(60 + k); host_data = rep(16'hA000 + 16'(k));
      step();
    end
    checks++; if (dmem_wren !== 1'b1 || dmem_addr !== AW'(69) || host_gnt !== 1'b1) begin
      errors++; $display("FAIL midburst_pre: got wren=%b addr=%0d gnt=%b exp 1 69 1", dmem_wren, dmem_addr, host_gnt); end
    rst = 1; host_addr = AW'(7'h55);
    step();
    rst = 0; host_wren = 0; host_req = 0; cam_req = 1;
    checks++; if (host_gnt !== 1'b0 || cam_gnt !== 1'b0 || busy !== 1'b0 || dmem_wren !== 1'b0 ||
                  dmem_addr !== '0 || dmem_data !== '0 || err_drop !== 2'b00) begin
      errors++; $display("FAIL midburst_reset: got hg=%b cg=%b busy=%b wren=%b addr=%h err=%b exp all 0",
                         host_gnt, cam_gnt, busy, dmem_wren, dmem_addr, err_drop); end
    step();
    checks++; if (cam_gnt !== 1'b1 || host_gnt !== 1'b0) begin
      errors++; $display("FAIL midburst_regrant: got cam=%b host=%b exp 1 0", cam_gnt, host_gnt); end
    cam_req = 0;
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_cam_only();
    test_tie();
    test_round_robin();
    test_drop();
    test_burst_limit();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
